// File: rtl/ctrl_pkg.sv
// Shared opcode constants, fetch FSM states and helpers for the fetch/issue stage.
package ctrl_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_SHL  = 3'b010;
   localparam logic [2:0] OP_SHR  = 3'b011;
   localparam logic [2:0] OP_SRA  = 3'b100;
   localparam logic [2:0] OP_LOG  = 3'b101;
   localparam logic [2:0] OP_CMP  = 3'b110;
   localparam logic [2:0] OP_HALT = 3'b111;

   typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALTED} fetch_state_e;

   // Issue counter that sticks at its maximum instead of wrapping.
   function automatic logic [15:0] cnt_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port plus issue handshake towards the decoder.
// master = fetch stage, slave = memory/decoder side.
interface instr_fetch_if #(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 16
);
   logic               imem_rd;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_data;
   logic               imem_valid;
   logic [2:0]         op;
   logic [INSTR_W-4:0] imm;
   logic               issue_valid;
   logic               issue_ready;

   modport master (
      output imem_rd, imem_addr, op, imm, issue_valid,
      input  imem_data, imem_valid, issue_ready
   );

   modport slave (
      input  imem_rd, imem_addr, op, imm, issue_valid,
      output imem_data, imem_valid, issue_ready
   );
endinterface

// File: rtl/instr_fetch_buf.sv
// One-entry holding register (valid + data) used as the prefetch buffer.
// Flush wins over load, load wins over pop; the fetch stage never loads and pops together.
module instr_buf #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] din,
   output logic         vld,
   output logic [W-1:0] dout
);

   // Single entry: fill on load, empty on pop or flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld  <= 1'b0;
         dout <= '0;
      end else if (flush) begin
         vld <= 1'b0;
      end else if (load) begin
         vld  <= 1'b1;
         dout <= din;
      end else if (pop) begin
         vld <= 1'b0;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/issue stage: reads IMEM at PC into IR and hands OP/IMM to the
// decoder over a valid/ready handshake, stopping at HALT until the next START.
// Optional macro INSTR_FETCH_PREFETCH_EN adds a one-entry prefetch buffer that reads
// PC+1 while the current instruction waits in ISSUE.
module instr_fetch
   import ctrl_pkg::*;
#(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [PC_W-1:0] start_pc,
   instr_fetch_if.master   bus,
   output logic            busy,
   output logic            halted,
   output logic [15:0]     instr_cnt
);

   fetch_state_e       state;
   logic [PC_W-1:0]    pc;
   logic [PC_W-1:0]    pc_nxt;
   logic [INSTR_W-1:0] ir;
   logic               hs;
   logic               go;
   // Word available to replace IR at the handshake without going back to FETCH.
   logic               nxt_rdy;
   logic [INSTR_W-1:0] nxt_word;

   assign pc_nxt          = pc + 1'b1;
   assign hs              = (state == ISSUE) && bus.issue_ready;
   assign go              = start && ((state == IDLE) || (state == HALTED));
   assign bus.op          = ir[INSTR_W-1 -: 3];
   assign bus.imm         = ir[INSTR_W-4:0];
   assign bus.issue_valid = (state == ISSUE);
   assign busy            = (state == FETCH) || (state == ISSUE);
   assign halted          = (state == HALTED);

`ifdef INSTR_FETCH_PREFETCH_EN
   logic               pf_vld;
   logic [INSTR_W-1:0] pf_q;
   logic               pf_load;
   logic               pf_pop;

   // In ISSUE the read port looks one ahead; address stays on PC+1 which becomes
   // PC after the handshake, so a pending read stays stable across ISSUE->FETCH.
   assign bus.imem_rd   = (state == FETCH) || ((state == ISSUE) && !pf_vld);
   assign bus.imem_addr = (state == ISSUE) ? pc_nxt : pc;

   // A response arriving on the handshake edge goes straight to IR instead.
   assign pf_load  = (state == ISSUE) && !pf_vld && bus.imem_valid && !hs;
   assign pf_pop   = hs && pf_vld;
   assign nxt_rdy  = pf_vld || ((state == ISSUE) && bus.imem_valid);
   assign nxt_word = pf_vld ? pf_q : bus.imem_data;

   instr_buf #(.W(INSTR_W)) u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (pf_load),
      .pop   (pf_pop),
      .flush (go),
      .din   (bus.imem_data),
      .vld   (pf_vld),
      .dout  (pf_q)
   );
`else
   assign bus.imem_rd   = (state == FETCH);
   assign bus.imem_addr = pc;
   assign nxt_rdy       = 1'b0;
   assign nxt_word      = '0;
`endif

   // Fetch/issue FSM with PC, IR and issue counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pc        <= '0;
         ir        <= '0;
         instr_cnt <= '0;
      end else begin
         case (state)
            IDLE, HALTED: begin
               if (go) begin
                  state     <= FETCH;
                  pc        <= start_pc;
                  instr_cnt <= '0;
               end
            end
            FETCH: begin
               if (bus.imem_valid) begin
                  ir    <= bus.imem_data;
                  state <= (bus.imem_data[INSTR_W-1 -: 3] == OP_HALT) ? HALTED : ISSUE;
               end
            end
            ISSUE: begin
               if (hs) begin
                  pc        <= pc_nxt;
                  instr_cnt <= cnt_inc(instr_cnt);
                  if (nxt_rdy) begin
                     ir    <= nxt_word;
                     state <= (nxt_word[INSTR_W-1 -: 3] == OP_HALT) ? HALTED : ISSUE;
                  end else begin
                     state <= FETCH;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: IMEM model with programmable latency, scoreboard
// of expected OP/IMM built from the memory image at START and compared on each handshake.
`timescale 1ns/1ps
module tb_instr_fetch;
   import ctrl_pkg::*;

   localparam int PC_W    = 8;
   localparam int INSTR_W = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  start_pc = '0;
   logic        busy;
   logic        halted;
   logic [15:0] instr_cnt;

   instr_fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

   instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .start_pc  (start_pc),
      .bus       (bus),
      .busy      (busy),
      .halted    (halted),
      .instr_cnt (instr_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // IMEM model: one response per request, after lat cycles of IMEM_RD
   logic [15:0] mem [256];
   int          lat = 1;
   int          wcnt = 0;
   logic        mv = 1'b0;
   logic [15:0] md = '0;
   logic        spur = 1'b0;
   logic        rdy = 1'b0;

   assign bus.imem_valid  = mv | spur;
   assign bus.imem_data   = spur ? 16'hE5A5 : md;
   assign bus.issue_ready = rdy;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mv   <= 1'b0;
         wcnt <= 0;
      end else if (mv) begin
         mv <= 1'b0;
      end else if (bus.imem_rd) begin
         if (wcnt >= lat - 1) begin
            mv   <= 1'b1;
            md   <= mem[bus.imem_addr];
            wcnt <= 0;
         end else begin
            wcnt <= wcnt + 1;
         end
      end
   end

   // Scoreboard
   logic [15:0] sbq [$];
   int          hs_t [$];
   int          cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n && bus.issue_valid && bus.issue_ready) begin
         if (sbq.size() == 0) begin
            chk("sb_extra", 32'(sbq.size()), 1);
         end else begin
            logic [15:0] w;
            w = sbq.pop_front();
            chk("sb_op", 32'(bus.op), 32'(w[15:13]));
            chk("sb_imm", 32'(bus.imm), 32'(w[12:0]));
         end
         hs_t.push_back(cyc);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_prog(input logic [7:0] a);
      logic [7:0] p;
      p = a;
      for (int i = 0; i < 256; i++) begin
         if (mem[p][15:13] == OP_HALT) break;
         sbq.push_back(mem[p]);
         p = p + 8'd1;
      end
   endtask

   task automatic do_start(input logic [7:0] a);
      start_pc = a;
      start    = 1'b1;
      tick(1);
      start    = 1'b0;
   endtask

   task automatic wait_halt(input int maxc, input string tag);
      int n;
      n = 0;
      while (!halted && n < maxc) begin
         tick(1);
         n++;
      end
      chk({tag, "_halt"}, 32'(halted), 1);
      chk({tag, "_busy"}, 32'(busy), 0);
   endtask

   task automatic wait_valid(input int maxc, input string tag);
      int n;
      n = 0;
      while (!bus.issue_valid && n < maxc) begin
         tick(1);
         n++;
      end
      chk({tag, "_vld"}, 32'(bus.issue_valid), 1);
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, "_rd"},   32'(bus.imem_rd), 0);
      chk({tag, "_addr"}, 32'(bus.imem_addr), 0);
      chk({tag, "_op"},   32'(bus.op), 0);
      chk({tag, "_imm"},  32'(bus.imm), 0);
      chk({tag, "_vld"},  32'(bus.issue_valid), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_hlt"},  32'(halted), 0);
      chk({tag, "_cnt"},  32'(instr_cnt), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < 256; i++) mem[i] = {OP_HALT, 13'h0};
      mem[8'h10] = {OP_ADD, 13'h0011};
      mem[8'h11] = {OP_SUB, 13'h1ABC};
      mem[8'h30] = {OP_SHL, 13'h0003};
      mem[8'h31] = {OP_SHR, 13'h0FF0};
      mem[8'h40] = {OP_CMP, 13'h1234};
      mem[8'h41] = {OP_LOG, 13'h0555};
      mem[8'hFF] = {OP_ADD, 13'h1FFF};
      mem[8'h50] = {OP_SRA, 13'h0042};
      for (int i = 0; i < 4; i++) mem[8'h20 + i] = {OP_ADD, 13'(8'h20 + i)};

      // reset state
      tick(2);
      chk_rst("init");
      rst_n = 1'b1;
      tick(2);

      // T1: straight-line program ending in HALT
      lat = 1; rdy = 1'b1;
      push_prog(8'h10);
      do_start(8'h10);
      wait_halt(60, "t1");
      chk("t1_pc", 32'(bus.imem_addr), 32'h12);
      chk("t1_cnt", 32'(instr_cnt), 2);
      chk("t1_sb", 32'(sbq.size()), 0);

      // T2: downstream stall keeps OP/IMM stable
      rdy = 1'b0;
      push_prog(8'h30);
      do_start(8'h30);
      wait_valid(20, "t2");
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("t2_op", 32'(bus.op), 32'(OP_SHL));
         chk("t2_imm", 32'(bus.imm), 32'h0003);
         chk("t2_vld", 32'(bus.issue_valid), 1);
`ifndef INSTR_FETCH_PREFETCH_EN
         chk("t2_rd", 32'(bus.imem_rd), 0);
`endif
      end
      rdy = 1'b1;
      tick(1);
      rdy = 1'b0;
`ifdef INSTR_FETCH_PREFETCH_EN
      chk("t2_pf_keep", 32'(bus.issue_valid), 1);
      chk("t2_pf_op", 32'(bus.op), 32'(OP_SHR));
`else
      chk("t2_drop", 32'(bus.issue_valid), 0);
      chk("t2_refetch", 32'(bus.imem_rd), 1);
`endif
      tick(3);
      chk("t2_one", 32'(instr_cnt), 1);
      chk("t2_op2", 32'(bus.op), 32'(OP_SHR));
      rdy = 1'b1;
      wait_halt(40, "t2");
      chk("t2_cnt", 32'(instr_cnt), 2);
      chk("t2_pc", 32'(bus.imem_addr), 32'h32);
      chk("t2_sb", 32'(sbq.size()), 0);

      // T3: 4-cycle memory, request held stable; spurious valid in ISSUE
      lat = 4; rdy = 1'b0;
      push_prog(8'h40);
      do_start(8'h40);
      n = 0;
      while (!bus.issue_valid && n < 20) begin
         chk("t3_rd", 32'(bus.imem_rd), 1);
         chk("t3_addr", 32'(bus.imem_addr), 32'h40);
         tick(1);
         n++;
      end
      chk("t3_lat", 32'(n), 5);
`ifndef INSTR_FETCH_PREFETCH_EN
      spur = 1'b1;
      tick(1);
      spur = 1'b0;
      chk("t3_spur_op", 32'(bus.op), 32'(OP_CMP));
      chk("t3_spur_vld", 32'(bus.issue_valid), 1);
      chk("t3_spur_hlt", 32'(halted), 0);
`endif
      rdy = 1'b1;
      wait_halt(80, "t3");
      chk("t3_cnt", 32'(instr_cnt), 2);
      chk("t3_pc", 32'(bus.imem_addr), 32'h42);
      chk("t3_sb", 32'(sbq.size()), 0);

      // T4: PC wrap FF -> 00
      lat = 1; rdy = 1'b1;
      push_prog(8'hFF);
      do_start(8'hFF);
      wait_halt(40, "t4");
      chk("t4_pc", 32'(bus.imem_addr), 32'h00);
      chk("t4_cnt", 32'(instr_cnt), 1);
      chk("t4_sb", 32'(sbq.size()), 0);

      // T5a: START ignored while busy, then reset during FETCH
      lat = 4; rdy = 1'b1;
      push_prog(8'h50);
      do_start(8'h50);
      tick(1);
      chk("t5_busy", 32'(busy), 1);
      start_pc = 8'h60; start = 1'b1;
      tick(1);
      start = 1'b0;
      chk("t5_ign_addr", 32'(bus.imem_addr), 32'h50);
      chk("t5_ign_rd", 32'(bus.imem_rd), 1);
      #3 rst_n = 1'b0;
      #1 chk_rst("t5f");
      sbq.delete();
      tick(2);
      rst_n = 1'b1;
      tick(1);

      // T5b: reset during ISSUE
      lat = 1; rdy = 1'b1;
      push_prog(8'h10);
      do_start(8'h10);
      n = 0;
      while (instr_cnt != 16'd1 && n < 20) begin
         tick(1);
         n++;
      end
      rdy = 1'b0;
      chk("t5_cnt1", 32'(instr_cnt), 1);
      wait_valid(20, "t5i");
      chk("t5i_op", 32'(bus.op), 32'(OP_SUB));
      #3 rst_n = 1'b0;
      #1 chk_rst("t5i");
      sbq.delete();
      tick(2);
      rst_n = 1'b1;
      tick(1);
      rdy = 1'b1;
      push_prog(8'h10);
      do_start(8'h10);
      wait_halt(60, "t5r");
      chk("t5r_cnt", 32'(instr_cnt), 2);
      chk("t5r_sb", 32'(sbq.size()), 0);

`ifdef INSTR_FETCH_PREFETCH_EN
      // T6: prefetch throughput, prefetched HALT not issued
      lat = 1; rdy = 1'b1;
      hs_t.delete();
      push_prog(8'h20);
      do_start(8'h20);
      wait_halt(60, "t6");
      chk("t6_nhs", 32'(hs_t.size()), 4);
      for (int i = 1; i < hs_t.size(); i++)
         chk("t6_gap", 32'(hs_t[i] - hs_t[i-1] <= 2), 1);
      chk("t6_cnt", 32'(instr_cnt), 4);
      chk("t6_pc", 32'(bus.imem_addr), 32'h24);
      chk("t6_sb", 32'(sbq.size()), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
